// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and FSM state types for the AXI4-Lite register file.
package regfile_pkg;
    localparam int REG_W = 32;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;
endpackage

// File: rtl/regfile_byte_we.sv
// regfile_byte_we: one register with byte-strobe merge; pulse registers clear every cycle.
module regfile_byte_we
    import regfile_pkg::*;
#(
    parameter bit PULSE = 1'b0
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,
    input  logic               we,
    input  logic [REG_W/8-1:0] strb,
    input  logic [REG_W-1:0]   wdata,
    output logic [REG_W-1:0]   q
);
    logic [REG_W-1:0] nxt;

    always_comb begin
        nxt = PULSE ? '0 : q;
        for (int b = 0; b < REG_W / 8; b++)
            if (we && strb[b]) nxt[8*b +: 8] = wdata[8*b +: 8];
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) q <= '0;
        else            q <= nxt;
    end
endmodule

// File: rtl/axi_regfile_gen.sv
// axi_regfile_gen: AXI4-Lite slave exposing NREGS 32-bit registers with
// read-only / self-clearing masks and per-register access strobes.
module axi_regfile_gen
    import regfile_pkg::*;
#(
    parameter int               NREGS      = 16,
    parameter int               ADDR_W     = 12,
    parameter logic [NREGS-1:0] RO_MASK    = '0,
    parameter logic [NREGS-1:0] PULSE_MASK = '0
) (
    input  logic                         axi_aclk,
    input  logic                         axi_areset,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [REG_W-1:0]             s_axi_wdata,
    input  logic [REG_W/8-1:0]           s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [REG_W-1:0]             s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NREGS-1:0][REG_W-1:0]  slv_reg,
    input  logic [NREGS-1:0][REG_W-1:0]  slv_read,
    output logic [NREGS-1:0]             slv_wr_stb,
    output logic [NREGS-1:0]             slv_rd_stb
);
    localparam int IW = $clog2(NREGS);

    wstate_e ws, ws_n;
    rstate_e rs, rs_n;
    logic [ADDR_W-1:0]  awaddr_q, wa;
    logic [REG_W-1:0]   wdata_q, wd;
    logic [REG_W/8-1:0] wstrb_q, wst;
    logic [IW-1:0]      widx, ridx;
    logic aw_hs, w_hs, ar_hs, commit, w_err, wr_ok, r_oor;
    logic unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

    assign s_axi_awready = !axi_areset && (ws == W_IDLE || ws == W_HAVE_DATA);
    assign s_axi_wready  = !axi_areset && (ws == W_IDLE || ws == W_HAVE_ADDR);
    assign s_axi_bvalid  = ws == W_RESP;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    // The commit edge is the one on which the later of AW/W is captured
    assign commit = (aw_hs || ws == W_HAVE_ADDR) && (w_hs || ws == W_HAVE_DATA);
    assign wa     = aw_hs ? s_axi_awaddr : awaddr_q;
    assign wd     = w_hs ? s_axi_wdata : wdata_q;
    assign wst    = w_hs ? s_axi_wstrb : wstrb_q;
    assign widx   = wa[IW+1:2];
    assign w_err  = ((wa >> (IW + 2)) != '0) || RO_MASK[widx];
    assign wr_ok  = commit && !w_err;

    always_comb begin
        ws_n = ws;
        if (commit)                            ws_n = W_RESP;
        else if (aw_hs)                        ws_n = W_HAVE_ADDR;
        else if (w_hs)                         ws_n = W_HAVE_DATA;
        else if (ws == W_RESP && s_axi_bready) ws_n = W_IDLE;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            ws          <= W_IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= RESP_OKAY;
            slv_wr_stb  <= '0;
        end else begin
            ws         <= ws_n;
            slv_wr_stb <= '0;
            if (aw_hs) awaddr_q <= s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) s_axi_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
            if (wr_ok)  slv_wr_stb[widx] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        regfile_byte_we #(.PULSE(PULSE_MASK[i])) u_reg (
            .axi_aclk  (axi_aclk),
            .axi_areset(axi_areset),
            .we        (wr_ok && widx == IW'(i)),
            .strb      (wst),
            .wdata     (wd),
            .q         (slv_reg[i])
        );
    end

    assign s_axi_arready = !axi_areset && rs == R_IDLE;
    assign s_axi_rvalid  = rs == R_DATA;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign ridx  = s_axi_araddr[IW+1:2];
    assign r_oor = (s_axi_araddr >> (IW + 2)) != '0;

    always_comb begin
        rs_n = rs;
        if (ar_hs)                             rs_n = R_DATA;
        else if (rs == R_DATA && s_axi_rready) rs_n = R_IDLE;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            rs          <= R_IDLE;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
            slv_rd_stb  <= '0;
        end else begin
            rs         <= rs_n;
            slv_rd_stb <= '0;
            if (ar_hs) begin
                s_axi_rdata <= r_oor ? '0 : slv_read[ridx];
                s_axi_rresp <= r_oor ? RESP_SLVERR : RESP_OKAY;
                if (!r_oor) slv_rd_stb[ridx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_regfile_gen.sv
// tb_axi_regfile_gen: directed and randomized AXI4-Lite traffic against a transaction-level model.
module tb_axi_regfile_gen;
    localparam int N = 16;
    localparam logic [N-1:0] RO = 16'h0001;
    localparam logic [N-1:0] PM = 16'h0008;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_bready = 1'b1, s_axi_rready = 1'b1;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [N-1:0][31:0] slv_reg, slv_read;
    logic [N-1:0] slv_wr_stb, slv_rd_stb;

    assign slv_read = slv_reg;

    axi_regfile_gen #(.NREGS(N), .ADDR_W(12), .RO_MASK(RO), .PULSE_MASK(PM)) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .slv_reg(slv_reg), .slv_read(slv_read), .slv_wr_stb(slv_wr_stb), .slv_rd_stb(slv_rd_stb)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready policy: 0 hold low, 1 hold high, 2 random each cycle
    int b_mode = 1, r_mode = 1;
    always @(posedge clk) begin
        #1;
        s_axi_bready = b_mode == 2 ? 1'($urandom_range(1)) : b_mode == 1;
        s_axi_rready = r_mode == 2 ? 1'($urandom_range(1)) : r_mode == 1;
    end

    int cnt_stb2 = 0, cnt_p3 = 0;
    always @(negedge clk) begin
        if (slv_wr_stb[2]) cnt_stb2++;
        if (slv_reg[3][0]) cnt_p3++;
    end

    // Transaction-level model: predicts what the outputs must be after the next rising edge
    logic [31:0] exp_reg[N], snap[N];
    logic        got_a, got_d, exp_bvalid, exp_rvalid;
    logic [11:0] ma;
    logic [31:0] md, exp_rdata;
    logic [3:0]  ms;
    logic [1:0]  exp_bresp, exp_rresp;
    logic [N-1:0] exp_wstb, exp_rstb;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, err;
    int          idx;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) exp_reg[i] = '0;
            {got_a, got_d, exp_bvalid, exp_rvalid} = '0;
            {exp_bresp, exp_rresp, exp_rdata, exp_wstb, exp_rstb} = '0;
        end
        chk("awready", 32'(s_axi_awready), 32'(!rst && !got_a && !exp_bvalid));
        chk("wready", 32'(s_axi_wready), 32'(!rst && !got_d && !exp_bvalid));
        chk("arready", 32'(s_axi_arready), 32'(!rst && !exp_rvalid));
        chk("bvalid", 32'(s_axi_bvalid), 32'(exp_bvalid));
        chk("bresp", 32'(s_axi_bresp), 32'(exp_bresp));
        chk("rvalid", 32'(s_axi_rvalid), 32'(exp_rvalid));
        chk("rresp", 32'(s_axi_rresp), 32'(exp_rresp));
        chk("rdata", s_axi_rdata, exp_rdata);
        chk("wr_stb", 32'(slv_wr_stb), 32'(exp_wstb));
        chk("rd_stb", 32'(slv_rd_stb), 32'(exp_rstb));
        for (int i = 0; i < N; i++) chk($sformatf("slv_reg[%0d]", i), slv_reg[i], exp_reg[i]);
        if (!rst) begin
            for (int i = 0; i < N; i++) snap[i] = exp_reg[i];
            for (int i = 0; i < N; i++) if (PM[i]) exp_reg[i] = '0;
            exp_wstb = '0;
            exp_rstb = '0;
            aw_hs = s_axi_awvalid && !got_a && !exp_bvalid;
            w_hs  = s_axi_wvalid && !got_d && !exp_bvalid;
            b_hs  = exp_bvalid && s_axi_bready;
            ar_hs = s_axi_arvalid && !exp_rvalid;
            r_hs  = exp_rvalid && s_axi_rready;
            if (aw_hs) begin got_a = 1'b1; ma = s_axi_awaddr; end
            if (w_hs) begin got_d = 1'b1; md = s_axi_wdata; ms = s_axi_wstrb; end
            if (b_hs) exp_bvalid = 1'b0;
            if (got_a && got_d) begin
                idx = int'(ma[5:2]);
                err = ma[11:6] != 0 || RO[idx];
                if (!err) begin
                    for (int b = 0; b < 4; b++) if (ms[b]) exp_reg[idx][8*b +: 8] = md[8*b +: 8];
                    exp_wstb[idx] = 1'b1;
                end
                exp_bvalid = 1'b1;
                exp_bresp  = err ? 2'b10 : 2'b00;
                {got_a, got_d} = 2'b00;
            end
            if (r_hs) exp_rvalid = 1'b0;
            if (ar_hs) begin
                idx = int'(s_axi_araddr[5:2]);
                err = s_axi_araddr[11:6] != 0;
                exp_rvalid = 1'b1;
                exp_rdata  = err ? 32'h0 : snap[idx];
                exp_rresp  = err ? 2'b10 : 2'b00;
                if (!err) exp_rstb[idx] = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_aw(input logic [11:0] a);
        bit hs = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = s_axi_awready; cyc(1); end
        s_axi_awvalid = 1'b0;
        chk("aw_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit hs = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = s_axi_wready; cyc(1); end
        s_axi_wvalid = 1'b0;
        chk("w_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_ar(input logic [11:0] a);
        bit hs = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = s_axi_arready; cyc(1); end
        s_axi_arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 32'd1);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit hs = 0;
        resp = 2'b11;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk); hs = s_axi_bvalid && s_axi_bready; resp = s_axi_bresp; cyc(1);
        end
        chk("b_handshake", 32'(hs), 32'd1);
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        d = 'x; resp = 2'b11;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk); hs = s_axi_rvalid && s_axi_rready; d = s_axi_rdata; resp = s_axi_rresp; cyc(1);
        end
        chk("r_handshake", 32'(hs), 32'd1);
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first; gap in cycles
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, output logic [1:0] resp);
        fork
            begin cyc(mode == 2 ? gap : 0); send_aw(a); end
            begin cyc(mode == 1 ? gap : 0); send_w(d, s); end
        join
        wait_b(resp);
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        send_ar(a);
        wait_r(d, resp);
    endtask

    function automatic logic [11:0] rnd_addr();
        logic [11:0] a = 12'($urandom);
        if ($urandom_range(7) != 0) a[11:6] = '0;
        return a;
    endfunction

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int c0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        chk("reg2_reset", slv_reg[2], 32'h0);
        cyc(1);

        c0 = cnt_stb2;
        do_write(12'h008, 32'h12345678, 4'hF, 0, 0, resp);
        chk("wr08_bresp", 32'(resp), 32'd0);
        chk("wr08_reg2", slv_reg[2], 32'h12345678);
        cyc(2);
        chk("wr08_stb_cycles", 32'(cnt_stb2 - c0), 32'd1);
        do_read(12'h008, d, resp);
        chk("rd08_rdata", d, 32'h12345678);
        chk("rd08_rresp", 32'(resp), 32'd0);

        do_write(12'h014, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
        do_write(12'h014, 32'hAABBCCDD, 4'h3, 2, 3, resp);
        chk("w_first_merge", slv_reg[5], 32'hFFFFCCDD);

        do_write(12'h000, 32'hDEADBEEF, 4'hF, 1, 2, resp);
        chk("ro_bresp", 32'(resp), 32'd2);
        chk("ro_reg0", slv_reg[0], 32'h0);
        do_read(12'h040, d, resp);
        chk("oor_rresp", 32'(resp), 32'd2);
        chk("oor_rdata", d, 32'h0);

        c0 = cnt_p3;
        do_write(12'h00C, 32'h00000001, 4'hF, 0, 0, resp);
        cyc(3);
        chk("pulse_cycles", 32'(cnt_p3 - c0), 32'd1);
        chk("pulse_cleared", slv_reg[3], 32'h0);

        b_mode = 0;
        cyc(2);
        fork send_aw(12'h004); send_w(32'h0BADF00D, 4'hF); join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bhold_bvalid", 32'(s_axi_bvalid), 32'd1);
            chk("bhold_readies", 32'({s_axi_awready, s_axi_wready}), 32'd0);
            cyc(1);
        end
        b_mode = 1;
        wait_b(resp);
        chk("bhold_bresp", 32'(resp), 32'd0);

        send_aw(12'h010);
        r_mode = 0;
        cyc(2);
        send_ar(12'h008);
        @(negedge clk);
        chk("rdata_held_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rdata_held", s_axi_rdata, 32'h12345678);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'h0);
        chk("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        r_mode = 1;
        @(negedge clk);
        chk("release_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        chk("release_reg2", slv_reg[2], 32'h0);
        cyc(1);

        b_mode = 2;
        r_mode = 2;
        fork
            for (int k = 0; k < 80; k++) begin
                logic [1:0] wr;
                do_write(rnd_addr(), $urandom, 4'($urandom), $urandom_range(2), $urandom_range(3), wr);
            end
            for (int k = 0; k < 80; k++) begin
                logic [31:0] rd;
                logic [1:0]  rr;
                do_read(rnd_addr(), rd, rr);
                cyc($urandom_range(2));
            end
        join
        b_mode = 1;
        r_mode = 1;
        cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_regfile_gen.md
AXI_REGFILE_GEN -- requirements
Module: axi_regfile_gen

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, giving the number of 32-bit registers (power of two, 4..256).
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving the AXI byte-address width (ADDR_W >= clog2(NREGS)+2).
REQ-003 The block SHALL have parameter RO_MASK [NREGS-1:0], default all 0; a 1 marks that register read-only.
REQ-004 The block SHALL have parameter PULSE_MASK [NREGS-1:0], default all 0; a 1 marks that register self-clearing.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 axi_aclk  in  1  clock.
REQ-007 axi_areset  in  1  asynchronous active-high reset.
REQ-008 s_axi_aw{addr,prot,valid,ready}  in/in/in/out  ADDR_W/3/1/1  AXI4-Lite write address channel.
REQ-009 s_axi_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  AXI4-Lite write data channel.
REQ-010 s_axi_b{resp,valid,ready}  out/out/in  2/1/1  AXI4-Lite write response channel.
REQ-011 s_axi_ar{addr,prot,valid,ready}  in/in/in/out  ADDR_W/3/1/1  AXI4-Lite read address channel.
REQ-012 s_axi_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  AXI4-Lite read data channel.
REQ-013 slv_reg  out  [NREGS][32]  software-written register contents.
REQ-014 slv_read  in  [NREGS][32]  values returned on read.
REQ-015 slv_wr_stb  out  NREGS  one-cycle pulse per register on an accepted write.
REQ-016 slv_rd_stb  out  NREGS  one-cycle pulse per register on an accepted read (e.g. FIFO pop).

Function
REQ-017 Index = addr[clog2(NREGS)+1:2]; addr[1:0] SHALL be ignored.
REQ-018 An address is out-of-range when addr[ADDR_W-1:clog2(NREGS)+2] != 0.
REQ-019 Write FSM SHALL use states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP; AW and W SHALL be accepted in either order or in the same cycle.
REQ-020 awready SHALL be high in W_IDLE and W_HAVE_DATA; wready SHALL be high in W_IDLE and W_HAVE_ADDR; both SHALL be low in W_RESP.
REQ-021 The cycle after both AW and W are captured, the register SHALL update per byte lane where wstrb=1, slv_wr_stb[idx] SHALL pulse once, and bvalid SHALL assert (W_RESP).
REQ-022 bresp SHALL be OKAY (00); it SHALL be SLVERR (10) for out-of-range or RO_MASK registers, in which case slv_reg and slv_wr_stb are unchanged.
REQ-023 bvalid/bresp SHALL hold until bready; on bvalid&&bready the FSM SHALL return to W_IDLE.
REQ-024 Read FSM SHALL use states R_IDLE and R_DATA; arready SHALL be high only in R_IDLE.
REQ-025 rvalid SHALL assert exactly 1 cycle after the AR handshake, with rdata = slv_read[idx] sampled at handshake and slv_rd_stb[idx] pulsing in that same cycle.
REQ-026 rdata/rresp SHALL be stable until rready; an out-of-range read SHALL return rdata=0, rresp=SLVERR and no strobe.
REQ-027 For each PULSE_MASK register, written bits SHALL be high for exactly one cycle, then clear to 0.
REQ-028 Read and write channels SHALL be independent; a same-cycle read of a register being written SHALL return the pre-write value.
REQ-029 Back-to-back throughput SHALL be one write per 2 cycles (with bready held high) and one read per 2 cycles (with rready held high).

Reset
REQ-030 On axi_areset, both FSMs SHALL go to idle, and slv_reg, strobes, bvalid, rvalid, bresp, rresp and rdata SHALL all be 0.
REQ-031 A reset asserted mid-transaction SHALL abandon the transaction without a response or strobe.
REQ-032 awready, wready and arready SHALL be 0 while reset is asserted, and 1 in the first cycle after release.

Structure
REQ-033 Package regfile_pkg SHALL hold the resp constants (RESP_OKAY, RESP_SLVERR), the write/read state enums and the REG_W=32 constant.
REQ-034 One sub-module, regfile_byte_we (byte-strobe merge with PULSE clear), SHALL be instantiated per register via generate.

Verification
REQ-035 With NREGS=16, write 0x12345678 to 0x08 with strb=F, then read 0x08 with slv_read looped back -> bresp=00, rdata=0x12345678, slv_wr_stb[2] pulses 1 cycle.
REQ-036 Write W before AW (3-cycle gap), strb=0x3, data 0xAABBCCDD over 0xFFFFFFFF -> slv_reg[idx]=0xFFFFCCDD.
REQ-037 With RO_MASK[0]=1, write 0x00 -> bresp=SLVERR, slv_reg[0] unchanged; read addr 0x40 -> rresp=SLVERR, rdata=0.
REQ-038 With PULSE_MASK[3]=1, write 0x1 to 0x0C -> slv_reg[3][0] high exactly one cycle.
REQ-039 Hold bready=0 for 5 cycles -> bvalid held and awready/wready low; assert reset mid-R_DATA -> rvalid=0 immediately, arready=1 after release.
